vpu_inst_dispatch: RTL and testbench

Instruction dispatcher that sits directly upstream of the VPU sequencer. It buffers 32-bit VPU instructions pushed by the host/controller in a small FIFO and issues them one at a time. It holds each instruction word stable on `vpu_inst` until the VPU reports completion with its single-cycle `done` pulse, then counts the retirement. It also retires NOP instructions locally without involving the VPU.

---
 rtl/vpu_pkg.sv | 24 ++
 rtl/vpu_inst_fifo.sv | 52 +++++
 rtl/vpu_inst_dispatch.sv | 126 ++++++++++++
 tb/tb_vpu_inst_dispatch.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
`default_nettype none
// vpu_pkg: shared VPU instruction format, opcode constants and dispatcher state encoding.
// Rev 1.0
package vpu_pkg;

  typedef struct packed {
    logic [7:0] rsvd;
    logic [4:0] addr_const;
    logic [4:0] addr_c;
    logic [4:0] addr_b;
    logic [4:0] addr_a;
    logic [3:0] opcode;
  } inst_t;

  localparam logic [3:0] OP_NOP = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } disp_state_t;

endpackage
`default_nettype wire

// File: rtl/vpu_inst_fifo.sv
`default_nettype none
// vpu_inst_fifo: synchronous FIFO with wrap-bit pointers and single-cycle flush.
// Rev 1.0
module vpu_inst_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  // Flush wins over both operations so the queue is truly empty afterwards.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/vpu_inst_dispatch.sv
`default_nettype none
// vpu_inst_dispatch: queues host instructions, issues them to the VPU one at a time, retires NOPs locally.
// Optional watchdog: define VPU_DISPATCH_TIMEOUT_EN. Rev 1.0
module vpu_inst_dispatch
  import vpu_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int OP_W        = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  input  logic                   flush,
  output logic [31:0]            vpu_inst,
  output logic                   vpu_start,
  output logic                   vpu_busy,
  input  logic                   vpu_done,
`ifdef VPU_DISPATCH_TIMEOUT_EN
  output logic                   err_timeout,
`endif
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       retired_cnt
);

  disp_state_t state;
  disp_state_t state_nxt;
  inst_t       inst_reg;
  logic [31:0] head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        load;
  logic        retire;
  logic        wd_expired;

  assign in_ready  = !fifo_full && !flush;
  assign push      = in_valid && in_ready;
  assign vpu_start = (state == ST_ISSUE);
  assign vpu_busy  = (state != ST_IDLE);
  assign vpu_inst  = inst_reg;

  vpu_inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (in_inst),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    retire    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty && !flush) begin
          pop = 1'b1;
          if (head[OP_W-1:0] == OP_W'(OP_NOP)) begin
            retire = 1'b1;
          end else begin
            load      = 1'b1;
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A done arriving on the watchdog's last cycle still counts as a retirement.
        if (vpu_done) begin
          retire    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wd_expired) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      inst_reg    <= '0;
      retired_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load)   inst_reg    <= inst_t'(head);
      if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

`ifdef VPU_DISPATCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt <= (state == ST_WAIT) ? wd_cnt + WD_W'(1) : '0;
      if (state == ST_WAIT && !vpu_done && wd_expired) err_timeout <= 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vpu_inst_dispatch.sv
`default_nettype none
// tb_vpu_inst_dispatch: scenario tasks with a scoreboard of issued instruction words.
// Rev 1.0
module tb_vpu_inst_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic        flush = 1'b0;
  logic [31:0] vpu_inst;
  logic        vpu_start;
  logic        vpu_busy;
  logic        vpu_done = 1'b0;
  logic [3:0]  fifo_count;
  logic [15:0] retired_cnt;
`ifdef VPU_DISPATCH_TIMEOUT_EN
  logic        err_timeout;
`endif

  int checks = 0;
  int failures = 0;
  int starts_seen = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  vpu_inst_dispatch #(
    .DEPTH       (8),
    .OP_W        (4),
    .CNT_W       (16),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .flush       (flush),
    .vpu_inst    (vpu_inst),
    .vpu_start   (vpu_start),
    .vpu_busy    (vpu_busy),
    .vpu_done    (vpu_done),
`ifdef VPU_DISPATCH_TIMEOUT_EN
    .err_timeout (err_timeout),
`endif
    .fifo_count  (fifo_count),
    .retired_cnt (retired_cnt)
  );

  // Every issue is matched against the oldest expected word.
  always @(negedge clk) begin
    if (!rst && vpu_start === 1'b1) begin
      logic [31:0] w;
      starts_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL issue_unexpected vpu_inst=%h required no issue", vpu_inst);
      end else begin
        w = exp_q.pop_front();
        if (vpu_inst !== w) begin
          failures++;
          $display("FAIL issue_word vpu_inst=%h required %h", vpu_inst, w);
        end
      end
      checks++;
      if (vpu_busy !== 1'b1) begin
        failures++;
        $display("FAIL issue_busy vpu_busy=%b required 1", vpu_busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w, input bit expect_issue);
    in_inst  = w;
    in_valid = 1'b1;
    if (expect_issue) exp_q.push_back(w);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    while (vpu_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (vpu_start !== 1'b1) begin
      failures++;
      $display("FAIL wait_start vpu_start=%b after %0d cycles required 1", vpu_start, budget);
    end
  endtask

  task automatic complete_one();
    wait_start(40);
    tick();
    vpu_done = 1'b1;
    tick();
    vpu_done = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (in_ready !== 1'b1 || vpu_inst !== 32'h0 || vpu_start !== 1'b0 || vpu_busy !== 1'b0 ||
        fifo_count !== 4'd0 || retired_cnt !== 16'd0) begin
      failures++;
      $display("FAIL %s ready=%b inst=%h start=%b busy=%b count=%0d retired=%0d required 1 0 0 0 0 0",
               tag, in_ready, vpu_inst, vpu_start, vpu_busy, fifo_count, retired_cnt);
    end
`ifdef VPU_DISPATCH_TIMEOUT_EN
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL %s_err err_timeout=%b required 0", tag, err_timeout);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_reset_values("reset_values");
    rst = 1'b0;
  endtask

  task automatic test_single();
    push_word(32'h0000_2461, 1'b1);
    checks++;
    if (vpu_start !== 1'b0) begin
      failures++;
      $display("FAIL single_t1 vpu_start=%b required 0", vpu_start);
    end
    tick();
    checks++;
    if (vpu_start !== 1'b1 || vpu_inst !== 32'h0000_2461) begin
      failures++;
      $display("FAIL single_t2 start=%b inst=%h required 1 00002461", vpu_start, vpu_inst);
    end
    repeat (5) tick();
    vpu_done = 1'b1;
    tick();
    vpu_done = 1'b0;
    checks++;
    if (vpu_busy !== 1'b0 || retired_cnt !== 16'd1 || vpu_inst !== 32'h0000_2461) begin
      failures++;
      $display("FAIL single_done busy=%b retired=%0d inst=%h required 0 1 00002461",
               vpu_busy, retired_cnt, vpu_inst);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 9; i++) push_word({12'h0, 4'(i), 12'h0, 4'h3}, 1'b1);
    checks++;
    if (fifo_count !== 4'd8 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_count count=%0d ready=%b required 8 0", fifo_count, in_ready);
    end
    push_word(32'hDEAD_BEE5, 1'b0);
    checks++;
    if (fifo_count !== 4'd8) begin
      failures++;
      $display("FAIL full_reject count=%0d required 8", fifo_count);
    end
    vpu_done = 1'b1;
    tick();
    vpu_done = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready_d1 in_ready=%b required 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || fifo_count !== 4'd7) begin
      failures++;
      $display("FAIL full_ready_d2 ready=%b count=%0d required 1 7", in_ready, fifo_count);
    end
    for (int i = 0; i < 8; i++) complete_one();
    checks++;
    if (retired_cnt !== 16'd10 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL full_drain retired=%0d pending=%0d required 10 0", retired_cnt, exp_q.size());
    end
  endtask

  task automatic test_nop();
    logic [15:0] seen [3];
    int starts_before;
    starts_before = starts_seen;
    for (int i = 0; i < 4; i++) begin
      in_inst  = (i == 3) ? 32'h0000_0421 : {20'h0, 4'(i + 1), 8'h00};
      in_valid = 1'b1;
      if (i == 3) exp_q.push_back(32'h0000_0421);
      tick();
      if (i > 0) seen[i-1] = retired_cnt;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (seen[i] !== 16'(11 + i)) begin
        failures++;
        $display("FAIL nop_retire[%0d] retired=%0d required %0d", i, seen[i], 11 + i);
      end
    end
    complete_one();
    checks++;
    if (starts_seen != starts_before + 1 || retired_cnt !== 16'd14) begin
      failures++;
      $display("FAIL nop_add starts=%0d retired=%0d required %0d 14",
               starts_seen - starts_before, retired_cnt, 1);
    end
  endtask

  task automatic test_flush();
    int starts_before;
    starts_before = starts_seen;
    push_word(32'h0000_1112, 1'b1);
    wait_start(10);
    tick();
    for (int i = 0; i < 4; i++) push_word({24'h0, 4'(i), 4'h5}, 1'b0);
    checks++;
    if (fifo_count !== 4'd4) begin
      failures++;
      $display("FAIL flush_pre count=%0d required 4", fifo_count);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready in_ready=%b required 0", in_ready);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (fifo_count !== 4'd0 || vpu_busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_count count=%0d busy=%b required 0 1", fifo_count, vpu_busy);
    end
    vpu_done = 1'b1;
    tick();
    vpu_done = 1'b0;
    repeat (6) tick();
    checks++;
    if (retired_cnt !== 16'd15 || vpu_busy !== 1'b0 || starts_seen != starts_before + 1) begin
      failures++;
      $display("FAIL flush_after retired=%0d busy=%b starts=%0d required 15 0 1",
               retired_cnt, vpu_busy, starts_seen - starts_before);
    end
  endtask

  task automatic test_back_to_back();
    push_word(32'h0000_0A17, 1'b1);
    push_word(32'h0000_0B18, 1'b1);
    wait_start(10);
    tick();
    vpu_done = 1'b1;
    tick();
    vpu_done = 1'b0;
    checks++;
    if (vpu_start !== 1'b0 || vpu_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_d1 start=%b busy=%b required 0 0", vpu_start, vpu_busy);
    end
    tick();
    checks++;
    if (vpu_start !== 1'b1 || vpu_inst !== 32'h0000_0B18) begin
      failures++;
      $display("FAIL b2b_d2 start=%b inst=%h required 1 00000B18", vpu_start, vpu_inst);
    end
    complete_one();
    checks++;
    if (retired_cnt !== 16'd17) begin
      failures++;
      $display("FAIL b2b_retired retired=%0d required 17", retired_cnt);
    end
  endtask

  task automatic test_reset_mid();
    push_word(32'h0000_3339, 1'b1);
    wait_start(10);
    tick();
    push_word(32'h0000_444A, 1'b0);
    push_word(32'h0000_555B, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    tick();
    check_reset_values("reset_mid");
    rst = 1'b0;
    push_word(32'h0000_7770, 1'b0);
    tick();
    checks++;
    if (retired_cnt !== 16'd1 || vpu_busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_nop retired=%0d busy=%b required 1 0", retired_cnt, vpu_busy);
    end
  endtask

`ifdef VPU_DISPATCH_TIMEOUT_EN
  task automatic test_timeout();
    push_word(32'h0000_0C1C, 1'b1);
    push_word(32'h0000_0D1D, 1'b1);
    wait_start(10);
    repeat (16) tick();
    checks++;
    if (err_timeout !== 1'b0 || vpu_busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early err=%b busy=%b required 0 1", err_timeout, vpu_busy);
    end
    tick();
    checks++;
    if (err_timeout !== 1'b1 || vpu_busy !== 1'b0 || retired_cnt !== 16'd1) begin
      failures++;
      $display("FAIL timeout_fire err=%b busy=%b retired=%0d required 1 0 1",
               err_timeout, vpu_busy, retired_cnt);
    end
    tick();
    checks++;
    if (vpu_start !== 1'b1) begin
      failures++;
      $display("FAIL timeout_next vpu_start=%b required 1", vpu_start);
    end
    complete_one();
    checks++;
    if (retired_cnt !== 16'd2 || err_timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky retired=%0d err=%b required 2 1", retired_cnt, err_timeout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_full();
    test_nop();
    test_flush();
    test_back_to_back();
    test_reset_mid();
`ifdef VPU_DISPATCH_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded, checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "bench did not complete");
  end

endmodule
`default_nettype wire
